// File: rtl/wb_pipe_reg.sv
// Writeback pipeline register: DEPTH stages with stall/flush, registered occupancy count,
// and a forwarding lookup over all stages compiled in when WB_PIPE_FWD_EN is defined.
module wb_pipe_reg #(
  parameter int                DEPTH    = 1,
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 32,
  parameter int                TYPE_W   = 7,
  parameter logic [TYPE_W-1:0] NOP_TYPE = '0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [ADDR_W-1:0]            in_rd_addr,
  input  logic [DATA_W-1:0]            in_rd_val,
  input  logic [TYPE_W-1:0]            in_ins_type,
  output logic                         out_valid,
  output logic [ADDR_W-1:0]            out_rd_addr,
  output logic [DATA_W-1:0]            out_rd_val,
  output logic [TYPE_W-1:0]            out_ins_type,
  output logic                         out_we,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  input  logic [ADDR_W-1:0]            fwd_addr,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_val
);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic              r_valid [DEPTH];
  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [DATA_W-1:0] r_val   [DEPTH];
  logic [TYPE_W-1:0] r_type  [DEPTH];
  logic [OCC_W-1:0]  r_occ;

  logic              w_load    [DEPTH];
  logic              w_valid_d [DEPTH];
  logic [ADDR_W-1:0] w_addr_d  [DEPTH];
  logic [DATA_W-1:0] w_val_d   [DEPTH];
  logic [TYPE_W-1:0] w_type_d  [DEPTH];
  logic              w_valid_next [DEPTH];
  logic [OCC_W-1:0]  w_occ_next;

  // Flush only reaches stage 0 and replaces the incoming record with a bubble.
  assign w_load[0]    = flush | ~stall;
  assign w_valid_d[0] = ~flush & in_valid;
  assign w_addr_d[0]  = w_valid_d[0] ? in_rd_addr  : '0;
  assign w_val_d[0]   = w_valid_d[0] ? in_rd_val   : '0;
  assign w_type_d[0]  = w_valid_d[0] ? in_ins_type : NOP_TYPE;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_link
      assign w_load[gi]    = ~stall;
      assign w_valid_d[gi] = r_valid[gi-1];
      assign w_addr_d[gi]  = r_addr[gi-1];
      assign w_val_d[gi]   = r_val[gi-1];
      assign w_type_d[gi]  = r_type[gi-1];
    end
    for (gi = 0; gi < DEPTH; gi++) begin : g_next
      assign w_valid_next[gi] = w_load[gi] ? w_valid_d[gi] : r_valid[gi];
    end
  endgenerate

  always_comb begin
    w_occ_next = '0;
    for (int s = 0; s < DEPTH; s++) begin
      w_occ_next = w_occ_next + OCC_W'(w_valid_next[s]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_valid[s] <= 1'b0;
        r_addr[s]  <= '0;
        r_val[s]   <= '0;
        r_type[s]  <= NOP_TYPE;
      end
      r_occ <= '0;
    end else if (rdy_in) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (w_load[s]) begin
          r_valid[s] <= w_valid_d[s];
          r_addr[s]  <= w_addr_d[s];
          r_val[s]   <= w_val_d[s];
          r_type[s]  <= w_type_d[s];
        end
      end
      r_occ <= w_occ_next;
    end
  end

  assign out_valid    = r_valid[DEPTH-1];
  assign out_rd_addr  = r_addr[DEPTH-1];
  assign out_rd_val   = r_val[DEPTH-1];
  assign out_ins_type = r_type[DEPTH-1];
  assign out_we       = r_valid[DEPTH-1] && (r_addr[DEPTH-1] != '0);
  assign occ          = r_occ;

`ifdef WB_PIPE_FWD_EN
  // Scan oldest to youngest so the lowest-index match wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    if (fwd_addr != '0) begin
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (r_valid[s] && (r_addr[s] == fwd_addr)) begin
          fwd_hit = 1'b1;
          fwd_val = r_val[s];
        end
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_addr;
  assign fwd_hit      = 1'b0;
  assign fwd_val      = '0;
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg: DEPTH=3 and DEPTH=2 instances share stimulus and are checked
// against a queue-based reference model, with directed scenarios followed by random traffic.
module tb_wb_pipe_reg;
  localparam logic [6:0] NOP = 7'h13;

  typedef struct packed {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic [6:0]  t;
  } rec_t;
  typedef rec_t rq_t[$];

  logic        clk = 1'b0;
  logic        rst, rdy, stall, flush, in_valid;
  logic [4:0]  in_rd_addr, fwd_addr;
  logic [31:0] in_rd_val;
  logic [6:0]  in_ins_type;

  logic        o3_valid, o3_we, o3_fh, o2_valid, o2_we, o2_fh;
  logic [4:0]  o3_addr, o2_addr;
  logic [31:0] o3_val, o3_fv, o2_val, o2_fv;
  logic [6:0]  o3_type, o2_type;
  logic [1:0]  o3_occ, o2_occ;

  int total = 0;
  int bad   = 0;
  int stepn = 0;
  rq_t m3, m2;

  always #5 clk = ~clk;

  wb_pipe_reg #(.DEPTH(3), .ADDR_W(5), .DATA_W(32), .TYPE_W(7), .NOP_TYPE(NOP)) u3 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rd_addr(in_rd_addr), .in_rd_val(in_rd_val), .in_ins_type(in_ins_type),
    .out_valid(o3_valid), .out_rd_addr(o3_addr), .out_rd_val(o3_val), .out_ins_type(o3_type),
    .out_we(o3_we), .occ(o3_occ), .fwd_addr(fwd_addr), .fwd_hit(o3_fh), .fwd_val(o3_fv));

  wb_pipe_reg #(.DEPTH(2), .ADDR_W(5), .DATA_W(32), .TYPE_W(7), .NOP_TYPE(NOP)) u2 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rd_addr(in_rd_addr), .in_rd_val(in_rd_val), .in_ins_type(in_ins_type),
    .out_valid(o2_valid), .out_rd_addr(o2_addr), .out_rd_val(o2_val), .out_ins_type(o2_type),
    .out_we(o2_we), .occ(o2_occ), .fwd_addr(fwd_addr), .fwd_hit(o2_fh), .fwd_val(o2_fv));

  function automatic rec_t bubble();
    rec_t b;
    b = '{v: 1'b0, a: 5'd0, d: 32'd0, t: NOP};
    return b;
  endfunction

  // Index 0 of the queue is the youngest record, the back is what the outputs show.
  function automatic rq_t mstep(rq_t q, bit r, bit y, bit s, bit f, rec_t inr);
    rec_t b = bubble();
    if (r) begin
      foreach (q[i]) q[i] = b;
      return q;
    end
    if (!y) return q;
    if (!inr.v || f) inr = b;
    if (!s) begin
      q.push_front(inr);
      void'(q.pop_back());
    end else if (f) begin
      q[0] = b;
    end
    return q;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepn, obs, exp);
    end
  endtask

  task automatic check(input string nm, input rq_t q, input logic ov, input logic [4:0] oa,
                       input logic [31:0] od, input logic [6:0] ot, input logic owe,
                       input logic [1:0] oocc, input logic fh, input logic [31:0] fv);
    rec_t        last;
    int          n;
    logic        eh;
    logic [31:0] ev;
    last = q[q.size()-1];
    n = 0;
    foreach (q[i]) if (q[i].v) n++;
    eh = 1'b0;
    ev = 32'd0;
`ifdef WB_PIPE_FWD_EN
    if (fwd_addr != 5'd0) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].v && q[i].a == fwd_addr) begin
          eh = 1'b1;
          ev = q[i].d;
          break;
        end
      end
    end
`endif
    cmp({nm, ".out_valid"},    32'(ov),   32'(last.v));
    cmp({nm, ".out_rd_addr"},  32'(oa),   32'(last.a));
    cmp({nm, ".out_rd_val"},   od,        last.d);
    cmp({nm, ".out_ins_type"}, 32'(ot),   32'(last.t));
    cmp({nm, ".out_we"},       32'(owe),  32'(last.v && last.a != 5'd0));
    cmp({nm, ".occ"},          32'(oocc), 32'(n));
    cmp({nm, ".fwd_hit"},      32'(fh),   32'(eh));
    cmp({nm, ".fwd_val"},      fv,        ev);
  endtask

  task automatic step(input bit r, input bit y, input bit s, input bit f, input bit v,
                      input logic [4:0] a, input logic [31:0] d, input logic [6:0] t,
                      input logic [4:0] fa);
    rec_t inr;
    rst = r; rdy = y; stall = s; flush = f; in_valid = v;
    in_rd_addr = a; in_rd_val = d; in_ins_type = t; fwd_addr = fa;
    inr = '{v: v, a: a, d: d, t: t};
    @(posedge clk);
    m3 = mstep(m3, r, y, s, f, inr);
    m2 = mstep(m2, r, y, s, f, inr);
    #1;
    stepn++;
    check("d3", m3, o3_valid, o3_addr, o3_val, o3_type, o3_we, o3_occ, o3_fh, o3_fv);
    check("d2", m2, o2_valid, o2_addr, o2_val, o2_type, o2_we, o2_occ, o2_fh, o2_fv);
  endtask

  initial begin
    m3 = '{bubble(), bubble(), bubble()};
    m2 = '{bubble(), bubble()};
    rst = 1'b1; rdy = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_rd_addr = '0; in_rd_val = '0; in_ins_type = '0; fwd_addr = '0;

    // Reset, including reset overriding rdy_in=0, stall and flush.
    step(1, 1, 0, 0, 0, 5'd0, 32'h0, 7'h0, 5'd0);
    step(1, 0, 1, 1, 1, 5'd9, 32'h1, 7'h2, 5'd9);
    cmp("reset.out_ins_type", 32'(o3_type), 32'(NOP));

    // Three consecutive pushes; DEPTH=3 shows 0x11/0x22/0x33 on edges 3..5.
    step(0, 1, 0, 0, 1, 5'd1, 32'h11, 7'h33, 5'd1);
    step(0, 1, 0, 0, 1, 5'd2, 32'h22, 7'h33, 5'd2);
    step(0, 1, 0, 0, 1, 5'd3, 32'h33, 7'h33, 5'd3);
    cmp("req031.edge3", o3_val, 32'h11);
    cmp("req031.occ3", 32'(o3_occ), 32'd3);
    step(0, 1, 0, 0, 0, 5'd4, 32'h44, 7'h0, 5'd2);
    cmp("req031.edge4", o3_val, 32'h22);
    step(0, 1, 0, 0, 0, 5'd0, 32'h0, 7'h0, 5'd3);
    cmp("req031.edge5", o3_val, 32'h33);

    // Full pipe held by stall for four cycles, then drained.
    step(0, 1, 0, 0, 1, 5'd10, 32'hA0, 7'h05, 5'd0);
    step(0, 1, 0, 0, 1, 5'd11, 32'hB0, 7'h06, 5'd0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 0, 1, 5'($urandom), $urandom, 7'($urandom), 5'd10);
    cmp("req032.occ_held", 32'(o2_occ), 32'd2);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, 0, 5'd0, 32'h0, 7'h0, 5'd11);

    // Flush while stalled: only stage 0 becomes a bubble.
    step(0, 1, 0, 0, 1, 5'd4, 32'h40, 7'h01, 5'd0);
    step(0, 1, 0, 0, 1, 5'd5, 32'h50, 7'h01, 5'd5);
    step(0, 1, 1, 1, 1, 5'd6, 32'h60, 7'h01, 5'd5);
    cmp("req033.occ", 32'(o2_occ), 32'd1);
    cmp("req033.held_addr", 32'(o2_addr), 32'd4);

    // Address-0 record reaches the output without a write enable; rdy_in low freezes.
    step(0, 1, 0, 0, 1, 5'd0, 32'hDEAD, 7'h02, 5'd0);
    step(0, 1, 0, 0, 0, 5'd0, 32'h0, 7'h0, 5'd0);
    step(0, 1, 0, 0, 0, 5'd0, 32'h0, 7'h0, 5'd0);
    cmp("req034.valid", 32'(o3_valid), 32'd1);
    cmp("req034.we", 32'(o3_we), 32'd0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 1'($urandom), 1'($urandom), 1, 5'($urandom), $urandom, 7'($urandom), 5'd0);
    cmp("req034.frozen_val", o3_val, 32'hDEAD);

    // Two stages hold addr 7; forwarding must pick the youngest.
    step(0, 1, 0, 0, 1, 5'd7, 32'hB, 7'h03, 5'd7);
    step(0, 1, 0, 0, 1, 5'd3, 32'hC, 7'h03, 5'd7);
    step(0, 1, 0, 0, 1, 5'd7, 32'hA, 7'h03, 5'd7);
`ifdef WB_PIPE_FWD_EN
    cmp("req035.fwd_val", o3_fv, 32'hA);
`endif
    step(0, 0, 0, 0, 0, 5'd0, 32'h0, 7'h0, 5'd0);

    // Reset with a full pipe and stall asserted.
    step(0, 1, 0, 0, 1, 5'd8, 32'h81, 7'h04, 5'd0);
    step(0, 1, 0, 0, 1, 5'd9, 32'h91, 7'h04, 5'd0);
    step(0, 1, 0, 0, 1, 5'd12, 32'hC1, 7'h04, 5'd0);
    step(1, 1, 1, 0, 1, 5'd13, 32'hD1, 7'h04, 5'd9);
    cmp("req036.occ", 32'(o3_occ), 32'd0);
    cmp("req036.we", 32'(o3_we), 32'd0);
    cmp("req036.type", 32'(o3_type), 32'(NOP));

    // Random traffic over small address space so forwarding hits are frequent.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
           $urandom, 7'($urandom), 5'($urandom_range(0, 7)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
